// File: rtl/ysyx_2022040010_ex_div_pkg.sv
// Shared definitions for the EX-stage divider: widths, stall-bus encodings,
// div-op bit positions used by the ID decoder, FSM state type and operand helpers.
package ysyx_2022040010_ex_div_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  localparam int STALL_WD = 6;
  typedef logic [STALL_WD-1:0] stall_bus_t;
  localparam stall_bus_t STALL_NONE    = 6'b000000;
  localparam stall_bus_t STALL_FROM_EX = 6'b001111;

  localparam int DIV_OP_SIGNED_BIT = 0;
  localparam int DIV_OP_REM_BIT    = 1;
  localparam int DIV_OP_WORD_BIT   = 2;

  // Field order mirrors the bit positions above (word is the MSB).
  typedef struct packed {
    logic word;
    logic rem;
    logic sgn;
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  function automatic logic [XLEN-1:0] op_ext(input logic [XLEN-1:0] v,
                                             input logic word,
                                             input logic sgn);
    if (!word)
      return v;
    else if (sgn)
      return {{(XLEN/2){v[XLEN/2-1]}}, v[XLEN/2-1:0]};
    else
      return {{(XLEN/2){1'b0}}, v[XLEN/2-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return {{(XLEN/2){v[XLEN/2-1]}}, v[XLEN/2-1:0]};
  endfunction

endpackage

// File: rtl/ysyx_2022040010_ex_div_if.sv
// EX <-> divider handshake: request side (master) and divider side (slave).
interface ysyx_2022040010_ex_div_if;
  import ysyx_2022040010_ex_div_pkg::*;

  logic            div_valid;
  logic            div_signed;
  logic            div_rem;
  logic            div_word;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            stallreq_for_ex;
  logic            div_ready;
  logic [XLEN-1:0] div_result;

  modport master (
    output div_valid, div_signed, div_rem, div_word, src1, src2, flush,
    input  stallreq_for_ex, div_ready, div_result
  );

  modport slave (
    input  div_valid, div_signed, div_rem, div_word, src1, src2, flush,
    output stallreq_for_ex, div_ready, div_result
  );

endinterface

// File: rtl/ysyx_2022040010_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract divisor.
module ysyx_2022040010_div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted = {rem_in, quo_in[W-1]};
  // rem_in < divisor keeps shifted below 2*divisor, so diff[W] is a clean borrow.
  assign diff    = shifted - {1'b0, divisor};
  assign rem_out = diff[W] ? shifted[W-1:0] : diff[W-1:0];
  assign quo_out = {quo_in[W-2:0], ~diff[W]};

endmodule

// File: rtl/ysyx_2022040010_ex_div.sv
// Iterative RV64M divider for EX; raises stallreq_for_ex while an op is in flight.
// Optional macro DIV_FAST_PATH_EN: divide-by-zero / signed overflow skip straight to DONE.
module ysyx_2022040010_ex_div
  import ysyx_2022040010_ex_div_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  ysyx_2022040010_ex_div_if.slave       div_if
);

  localparam logic [CNT_W-1:0] STEPS_D = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] STEPS_W = CNT_W'(XLEN/2);
  localparam logic [XLEN-1:0]  MIN_D   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  MIN_W   = {{(XLEN/2+1){1'b1}}, {(XLEN/2-1){1'b0}}};
  localparam logic [XLEN-1:0]  MIN_W_Q = {{(XLEN/2){1'b0}}, 1'b1, {(XLEN/2-1){1'b0}}};

  div_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0]  rem_reg, quo_reg, dvs_reg, dvd_reg;
  div_op_t          op_reg;
  logic             q_neg_reg, r_neg_reg, dz_reg, ovf_reg;

  logic             issue, fast_done;
  logic [XLEN-1:0]  dvd_ext, dvs_ext, dvd_abs, dvs_abs;
  logic             dvd_neg, dvs_neg, dz, ovf;
  logic [XLEN-1:0]  rem_step, quo_step;
  logic [XLEN-1:0]  q_fin, r_fin, sel, res_final;
  logic             stall_out, ready_out;
  logic [XLEN-1:0]  result_out;

  assign issue   = (state_reg == S_IDLE) && div_if.div_valid && !div_if.flush;
  assign dvd_ext = op_ext(div_if.src1, div_if.div_word, div_if.div_signed);
  assign dvs_ext = op_ext(div_if.src2, div_if.div_word, div_if.div_signed);
  assign dvd_neg = div_if.div_signed && dvd_ext[XLEN-1];
  assign dvs_neg = div_if.div_signed && dvs_ext[XLEN-1];
  assign dvd_abs = dvd_neg ? -dvd_ext : dvd_ext;
  assign dvs_abs = dvs_neg ? -dvs_ext : dvs_ext;
  assign dz      = (dvs_ext == '0);
  assign ovf     = div_if.div_signed && (dvs_ext == '1) &&
                   (dvd_ext == (div_if.div_word ? MIN_W : MIN_D));

`ifdef DIV_FAST_PATH_EN
  assign fast_done = dz || ovf;
`else
  assign fast_done = 1'b0;
`endif

  ysyx_2022040010_div_step #(.W(XLEN)) u_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .divisor (dvs_reg),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (issue) state_next = fast_done ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt_reg == CNT_W'(1)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (div_if.flush)
      state_next = S_IDLE;
  end

  // W ops park the 32-bit dividend in the upper half so 32 shifts consume it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      dvd_reg   <= '0;
      op_reg    <= '0;
      q_neg_reg <= 1'b0;
      r_neg_reg <= 1'b0;
      dz_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (issue) begin
      cnt_reg   <= div_if.div_word ? STEPS_W : STEPS_D;
      rem_reg   <= '0;
      quo_reg   <= div_if.div_word ? {dvd_abs[XLEN/2-1:0], {(XLEN/2){1'b0}}} : dvd_abs;
      dvs_reg   <= dvs_abs;
      dvd_reg   <= dvd_ext;
      op_reg    <= '{word: div_if.div_word, rem: div_if.div_rem, sgn: div_if.div_signed};
      q_neg_reg <= dvd_neg ^ dvs_neg;
      r_neg_reg <= dvd_neg;
      dz_reg    <= dz;
      ovf_reg   <= ovf;
    end else if (state_reg == S_BUSY) begin
      cnt_reg   <= cnt_reg - CNT_W'(1);
      rem_reg   <= rem_step;
      quo_reg   <= quo_step;
    end
  end

  always_comb begin
    q_fin = q_neg_reg ? -quo_reg : quo_reg;
    r_fin = r_neg_reg ? -rem_reg : rem_reg;
    if (dz_reg) begin
      q_fin = '1;
      r_fin = dvd_reg;
    end else if (ovf_reg) begin
      q_fin = op_reg.word ? MIN_W_Q : MIN_D;
      r_fin = '0;
    end
    sel       = op_reg.rem ? r_fin : q_fin;
    res_final = op_reg.word ? sext_word(sel) : sel;
  end

  always_comb begin
    stall_out  = 1'b0;
    ready_out  = 1'b0;
    result_out = '0;
    case (state_reg)
      S_IDLE: stall_out = div_if.div_valid && !div_if.flush;
      S_BUSY: stall_out = !div_if.flush;
      S_DONE: begin
        ready_out  = !div_if.flush;
        result_out = div_if.flush ? '0 : res_final;
      end
      default: ;
    endcase
    if (rst) begin
      stall_out  = 1'b0;
      ready_out  = 1'b0;
      result_out = '0;
    end
  end

  assign div_if.stallreq_for_ex = stall_out;
  assign div_if.div_ready       = ready_out;
  assign div_if.div_result      = result_out;

endmodule

// File: tb/tb_ysyx_2022040010_ex_div.sv
// Directed bench for the EX divider: stimulus pushes expected results, a monitor pops on div_ready.
module tb_ysyx_2022040010_ex_div;
  import ysyx_2022040010_ex_div_pkg::*;

`ifdef DIV_FAST_PATH_EN
  localparam int SPC_D = 2;
  localparam int SPC_W = 2;
`else
  localparam int SPC_D = 66;
  localparam int SPC_W = 34;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_2022040010_ex_div_if dif();

  ysyx_2022040010_ex_div dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Scoreboard monitor: every div_ready pulse must match the oldest expectation.
  initial begin : monitor
    logic [63:0] e;
    string nm;
    forever begin
      @(negedge clk);
      if (dif.div_ready === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_ready: result=%h, required no result", dif.div_result);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (dif.div_result !== e) begin
            n_err++;
            $display("FAIL %s: result=%h, required %h", nm, dif.div_result, e);
          end else begin
            $display("result %s = %h", nm, dif.div_result);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic set_op(input logic sgn, input logic rm, input logic wd,
                        input logic [63:0] a, input logic [63:0] b);
    dif.div_signed = sgn;
    dif.div_rem    = rm;
    dif.div_word   = wd;
    dif.src1       = a;
    dif.src2       = b;
    dif.div_valid  = 1'b1;
  endtask

  // Issue one op, hold it until div_ready, check EX occupancy and stall cycles.
  task automatic run_op(input string nm, input logic sgn, input logic rm, input logic wd,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_cyc);
    int cyc;
    int stl;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk); #1;
    set_op(sgn, rm, wd, a, b);
    cyc = 0;
    stl = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (dif.stallreq_for_ex === 1'b1) stl++;
    end while (dif.div_ready !== 1'b1 && cyc < 200);
    check({nm, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    check({nm, "_stall"}, 64'(stl), 64'(exp_cyc - 1));
    $display("op %s a=%h b=%h cycles=%0d stall=%0d", nm, a, b, cyc, stl);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    dif.div_valid = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    dif.div_valid  = 1'b0;
    dif.div_signed = 1'b0;
    dif.div_rem    = 1'b0;
    dif.div_word   = 1'b0;
    dif.src1       = '0;
    dif.src2       = '0;
    dif.flush      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall", 64'(dif.stallreq_for_ex), 64'd0);
    check("reset_ready", 64'(dif.div_ready), 64'd0);
    check("reset_result", dif.div_result, 64'd0);
    dif.div_valid = 1'b1;
    @(negedge clk);
    check("reset_dominates_valid", 64'(dif.stallreq_for_ex), 64'd0);
    dif.div_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("divu_100_7", 1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 66);
    idle(2);
    run_op("remu_100_7", 1'b0, 1'b1, 1'b0, 64'd100, 64'd7, 64'd2, 66);
    idle(2);
    run_op("div_m7_2", 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 66);
    idle(2);
    run_op("rem_m7_2", 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 66);
    idle(2);
    run_op("divw_1_8000_0000_1", 1'b1, 1'b0, 1'b1, 64'h0000_0001_8000_0000, 64'd1,
           64'hFFFF_FFFF_8000_0000, 34);
    idle(2);
    run_op("remw_m7_2", 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 34);
    idle(2);
    run_op("divuw_ffffffff_2", 1'b0, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2,
           64'h0000_0000_7FFF_FFFF, 34);
    idle(2);
    run_op("div_min_m1", 1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, SPC_D);
    idle(2);
    run_op("rem_min_m1", 1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, SPC_D);
    idle(2);
    run_op("divu_5_0", 1'b0, 1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SPC_D);
    idle(2);
    run_op("remu_5_0", 1'b0, 1'b1, 1'b0, 64'd5, 64'd0, 64'd5, SPC_D);
    idle(2);
    run_op("divw_min_m1", 1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, SPC_W);
    idle(2);
    run_op("remw_1_8000_0001_0", 1'b1, 1'b1, 1'b1, 64'h0000_0001_8000_0001, 64'd0,
           64'hFFFF_FFFF_8000_0001, SPC_W);

    // Back to back: no idle gap, the second op issues the cycle after DONE.
    run_op("b2b_divu_1000_10", 1'b0, 1'b0, 1'b0, 64'd1000, 64'd10, 64'd100, 66);
    run_op("b2b_divu_255_16", 1'b0, 1'b0, 1'b0, 64'd255, 64'd16, 64'd15, 66);
    idle(2);

    // Flush at BUSY step 10, with operands changed mid-flight.
    @(posedge clk); #1;
    set_op(1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    @(posedge clk); #1;
    dif.src1 = 64'd12345;
    repeat (9) @(posedge clk);
    #1 dif.flush = 1'b1;
    @(negedge clk);
    check("flush_stall", 64'(dif.stallreq_for_ex), 64'd0);
    check("flush_ready", 64'(dif.div_ready), 64'd0);
    @(posedge clk); #1;
    dif.flush     = 1'b0;
    dif.div_valid = 1'b0;
    @(negedge clk);
    check("after_flush_idle_stall", 64'(dif.stallreq_for_ex), 64'd0);
    repeat (70) @(negedge clk);
    run_op("divu_9_3_after_flush", 1'b0, 1'b0, 1'b0, 64'd9, 64'd3, 64'd3, 66);
    idle(2);

    // Reset mid-BUSY.
    @(posedge clk); #1;
    set_op(1'b0, 1'b0, 1'b0, 64'd255, 64'd16);
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy_stall", 64'(dif.stallreq_for_ex), 64'd0);
    check("rst_busy_ready", 64'(dif.div_ready), 64'd0);
    check("rst_busy_result", dif.div_result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dif.div_valid = 1'b0;
    @(negedge clk);
    check("rst_busy_idle_stall", 64'(dif.stallreq_for_ex), 64'd0);
    repeat (70) @(negedge clk);

    run_op("divu_9_3_after_rst", 1'b0, 1'b0, 1'b0, 64'd9, 64'd3, 64'd3, 66);
    idle(5);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
